// File: rtl/mod_exp_engine.sv
// Constant-time right-to-left modular exponentiation: result = base^exponent mod modulus.
// One bit-serial interleaved modular multiplier is shared by the reduce, multiply and square phases.
module mod_exp_engine #(
    parameter int WIDTH     = 128,
    parameter int EXP_WIDTH = 128
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     base,
    input  logic [EXP_WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0]     modulus,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [WIDTH-1:0]     result,
    output logic [2:0]           dbg_state
);

    // Handshake: start is accepted on a rising edge only while IDLE; busy stays high
    // through the computation; done pulses for exactly one cycle with result/error valid,
    // and both stay held until the next accepted start.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REDUCE = 3'd1,
        S_MUL    = 3'd2,
        S_SQR    = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int EW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(WIDTH - 1);
    localparam logic [EW-1:0] EBIT_LAST = EW'(EXP_WIDTH - 1);

    state_t               state, state_nxt;
    logic [WIDTH-1:0]     base_r, n_r, b_r, r_r, acc;
    logic [EXP_WIDTH-1:0] exp_r;
    logic [CW-1:0]        cnt;
    logic [EW-1:0]        ebit;

    logic                 mod_bad, mul_last, mbit;
    logic [WIDTH-1:0]     mplier, mcand, dbl_red, acc_nxt;
    logic [WIDTH:0]       dbl, sum, n_ext;

    assign mod_bad   = (modulus < WIDTH'(2));
    assign mul_last  = (cnt == CNT_LAST);
    assign dbg_state = state;

    // Operand selection for the shared multiplier; r and b only change at multiply boundaries.
    always_comb begin
        mplier = base_r;
        mcand  = WIDTH'(1);
        case (state)
            S_MUL: begin
                mplier = r_r;
                mcand  = b_r;
            end
            S_SQR: begin
                mplier = b_r;
                mcand  = b_r;
            end
            default: ;
        endcase
    end

    // acc < n holds every cycle, so 2*acc and dbl_red+mcand both stay below 2n in WIDTH+1 bits.
    always_comb begin
        n_ext   = {1'b0, n_r};
        mbit    = mplier[CNT_LAST - cnt];
        dbl     = {acc, 1'b0};
        dbl_red = (dbl >= n_ext) ? WIDTH'(dbl - n_ext) : dbl[WIDTH-1:0];
        sum     = {1'b0, dbl_red} + (mbit ? {1'b0, mcand} : '0);
        acc_nxt = (sum >= n_ext) ? WIDTH'(sum - n_ext) : sum[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = mod_bad ? S_FINISH : S_REDUCE;
            end
            S_REDUCE: begin
                busy = 1'b1;
                if (mul_last) state_nxt = S_MUL;
            end
            S_MUL: begin
                busy = 1'b1;
                if (mul_last) state_nxt = S_SQR;
            end
            S_SQR: begin
                busy = 1'b1;
                if (mul_last) state_nxt = (ebit == EBIT_LAST) ? S_FINISH : S_MUL;
            end
            S_FINISH: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_r <= '0;
            n_r    <= '0;
            exp_r  <= '0;
            b_r    <= '0;
            r_r    <= '0;
            acc    <= '0;
            cnt    <= '0;
            ebit   <= '0;
            result <= '0;
            error  <= 1'b0;
        end else if (state == S_IDLE) begin
            if (start) begin
                base_r <= base;
                n_r    <= modulus;
                exp_r  <= exponent;
                b_r    <= '0;
                r_r    <= '0;
                acc    <= '0;
                cnt    <= '0;
                ebit   <= '0;
                result <= '0;
                error  <= mod_bad;
            end
        end else if (state == S_REDUCE || state == S_MUL || state == S_SQR) begin
            if (mul_last) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= acc_nxt;
                cnt <= cnt + CW'(1);
            end
            if (mul_last) begin
                if (state == S_REDUCE) begin
                    b_r <= acc_nxt;
                    r_r <= WIDTH'(1);
                end else if (state == S_MUL) begin
                    // Product is always computed; it is kept only for a set exponent bit.
                    if (exp_r[0]) r_r <= acc_nxt;
                end else begin
                    b_r   <= acc_nxt;
                    exp_r <= exp_r >> 1;
                    ebit  <= ebit + EW'(1);
                    if (ebit == EBIT_LAST) result <= r_r;
                end
            end
        end
    end

endmodule

// File: tb/tb_mod_exp_engine.sv
// Directed bench for mod_exp_engine (16-bit): literal result/latency checks plus a
// cycle-by-cycle comparison against a behavioural square-and-multiply model.
module tb_mod_exp_engine;

    localparam int W   = 16;
    localparam int E   = 16;
    localparam int LAT = 1 + W + 2 * W * E;

    logic         clk      = 1'b0;
    logic         reset_n  = 1'b0;
    logic         start    = 1'b0;
    logic [W-1:0] base     = '0;
    logic [E-1:0] exponent = '0;
    logic [W-1:0] modulus  = '0;
    logic         busy, done, error;
    logic [W-1:0] result;
    logic [2:0]   dbg_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mod_exp_engine #(.WIDTH(W), .EXP_WIDTH(E)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .base      (base),
        .exponent  (exponent),
        .modulus   (modulus),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .result    (result),
        .dbg_state (dbg_state)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_modexp(input logic [W-1:0] b, input logic [E-1:0] e,
                                                 input logic [W-1:0] n);
        longint unsigned r = 1;
        longint unsigned x = b % n;
        for (int i = 0; i < E; i++) begin
            if (e[i]) r = (r * x) % n;
            x = (x * x) % n;
        end
        return r[W-1:0];
    endfunction

    // Behavioural model: 0 idle, 1 computing, 2 done cycle.
    int           m_phase = 0;
    int           m_left  = 0;
    logic [W-1:0] m_res   = '0;
    logic [W-1:0] m_pend  = '0;
    logic         m_err   = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_phase = 0;
            m_left  = 0;
            m_res   = '0;
            m_err   = 1'b0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    if (modulus < 2) begin
                        m_phase = 2;
                        m_res   = '0;
                        m_err   = 1'b1;
                    end else begin
                        m_phase = 1;
                        m_left  = LAT - 1;
                        m_err   = 1'b0;
                        m_pend  = ref_modexp(base, exponent, modulus);
                    end
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = 2;
                        m_res   = m_pend;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        chk("done", done, m_phase == 2);
        chk("busy", busy, m_phase == 1);
        chk("error", error, m_err);
        if (m_phase != 1) chk("result", result, m_res);
    end

    // Launch one operation; optionally pulse start with other operands while busy.
    task automatic run_op(input string name, input logic [W-1:0] b, input logic [E-1:0] e,
                          input logic [W-1:0] n, input logic [W-1:0] exp_res,
                          input logic exp_err, input int exp_lat, input int poke_at);
        int lat = 0;
        @(posedge clk); #1;
        base = b; exponent = e; modulus = n; start = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        base     = W'($urandom_range(0, 65535));
        exponent = E'($urandom_range(0, 65535));
        modulus  = W'($urandom_range(2, 65535));
        for (int i = 1; i <= LAT + 10 && lat == 0; i++) begin
            @(negedge clk);
            if (done) lat = i;
            if (poke_at != 0 && i == poke_at) begin
                base = 16'd65; exponent = 16'd17; modulus = 16'd3233; start = 1'b1;
            end
            if (poke_at != 0 && i == poke_at + 1) start = 1'b0;
        end
        chk({name, " latency"}, lat, exp_lat);
        chk({name, " result"}, result, exp_res);
        chk({name, " error"}, error, exp_err);
    endtask

    initial begin
        int seen;
        int ndone;
        int lat2;
        #1;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset result", result, 0);
        chk("reset state", dbg_state, 0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        run_op("basic", 16'd4, 16'd13, 16'd497, 16'd445, 1'b0, LAT, 0);
        run_op("rsa enc", 16'd65, 16'd17, 16'd3233, 16'd2790, 1'b0, LAT, 0);
        run_op("rsa dec", 16'd2790, 16'd2753, 16'd3233, 16'd65, 1'b0, LAT, 0);
        run_op("base>=n", 16'd500, 16'd13, 16'd497, 16'd444, 1'b0, LAT, 0);
        run_op("exp zero", 16'd500, 16'd0, 16'd497, 16'd1, 1'b0, LAT, 0);
        run_op("mod one", 16'd7, 16'd5, 16'd1, 16'd0, 1'b1, 1, 0);
        run_op("mod zero", 16'd7, 16'd5, 16'd0, 16'd0, 1'b1, 1, 0);
        run_op("clear err", 16'd4, 16'd13, 16'd497, 16'd445, 1'b0, LAT, 0);
        run_op("poke busy", 16'd4, 16'd13, 16'd497, 16'd445, 1'b0, LAT, 50);
        run_op("all ones", 16'hFFFF, 16'hFFFF, 16'hFFF1, ref_modexp(16'hFFFF, 16'hFFFF, 16'hFFF1),
               1'b0, LAT, 0);

        // Abort with reset at cycle 200, then restart.
        @(posedge clk); #1;
        base = 16'd65; exponent = 16'd17; modulus = 16'd3233; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seen  = 0;
        for (int i = 1; i < 200; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        @(negedge clk); #2;
        reset_n = 1'b0;
        #1;
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort result", result, 0);
        chk("abort state", dbg_state, 0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk("abort no done", seen, 0);
        run_op("restart", 16'd65, 16'd17, 16'd3233, 16'd2790, 1'b0, LAT, 0);

        // start held high: two operations back to back.
        @(posedge clk); #1;
        base = 16'd4; exponent = 16'd13; modulus = 16'd497; start = 1'b1;
        @(posedge clk);
        ndone = 0;
        lat2  = 0;
        for (int i = 1; i <= 2 * LAT + 20 && ndone < 2; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (ndone == 2) begin
                    lat2  = i;
                    start = 1'b0;
                end
            end
        end
        chk("b2b count", ndone, 2);
        chk("b2b latency", lat2, 2 * LAT + 1);
        chk("b2b result", result, 445);

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mod_exp_engine.md
MOD_EXP_ENGINE -- requirements
Module: mod_exp_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 128: operand, modulus and result width in bits.
REQ-002 SHALL have parameter EXP_WIDTH, default 128: exponent width in bits, scanned LSB first.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port base  input  WIDTH  message/ciphertext; any value, including base >= modulus.
REQ-007 SHALL have port exponent  input  EXP_WIDTH  public or private exponent.
REQ-008 SHALL have port modulus  input  WIDTH  n; values 0 and 1 are illegal.
REQ-009 SHALL have port busy  output  1  high from the cycle after start is accepted until done.
REQ-010 SHALL have port done  output  1  one-cycle pulse when result is valid.
REQ-011 SHALL have port error  output  1  set with done when modulus < 2; held until next accepted start.
REQ-012 SHALL have port result  output  WIDTH  base^exponent mod modulus; held until next accepted start.

Function
REQ-013 SHALL register base, exponent and modulus on the start-accept edge; input changes afterwards have no effect on the operation.
REQ-014 SHALL implement states IDLE, REDUCE, MUL, SQR, FINISH.
- IDLE -> REDUCE on start accept with modulus >= 2.
- IDLE -> FINISH on start accept with modulus < 2.
REQ-015 SHALL use one shared bit-serial interleaved modular multiplier: acc starts at 0, then for multiplier bits MSB to LSB, acc = 2*acc mod n, then + multiplicand if bit set, mod n. Exactly WIDTH cycles per multiply.
REQ-016 SHALL perform each mod n step with at most one conditional subtraction, using WIDTH+1-bit internal arithmetic, and SHALL guarantee acc < n after every cycle.
REQ-017 REDUCE SHALL compute b = base*1 mod n (multiplier = base, multiplicand = 1) in WIDTH cycles, set r = 1, then go to MUL.
REQ-018 For each exponent bit i = 0..EXP_WIDTH-1:
- MUL SHALL compute t = r*b mod n in WIDTH cycles; r = t only if exponent[i] = 1, otherwise t is discarded (constant time).
- SQR SHALL then compute b = b*b mod n in WIDTH cycles.
REQ-019 After SQR of bit EXP_WIDTH-1 SHALL enter FINISH; FINISH SHALL drive result = r, done = 1 for one cycle, then return to IDLE.
REQ-020 Latency SHALL be fixed and data-independent: done high in cycle 1 + WIDTH + 2*WIDTH*EXP_WIDTH after the accept edge.
REQ-021 Error path SHALL assert done and error together in cycle 1 after accept, with result = 0.
REQ-022 start while busy or in FINISH SHALL be ignored, without queueing; start held high in IDLE SHALL launch back-to-back operations.
REQ-023 exponent = 0 SHALL yield result = 1.
REQ-024 busy SHALL be low in IDLE and in the cycle done is high.

Reset
REQ-025 reset_n low SHALL immediately force IDLE and clear busy, done, error, result and all internal registers to 0, independent of clk.
REQ-026 reset_n asserted mid-operation SHALL abort it with no done pulse; the first start after release SHALL behave as from power-up.

Verification (WIDTH=16, EXP_WIDTH=16, latency 529 cycles)
REQ-027 base=4, exponent=13, modulus=497 -> done at cycle 529, result=445, error=0.
REQ-028 RSA pair, n=3233: base=65, e=17 -> 2790; then base=2790, e=2753 -> 65; latency identical for both.
REQ-029 base=500 (>= n), exponent=13, modulus=497 -> result=444; exponent=0 -> result=1.
REQ-030 modulus=1 or 0 -> done and error=1 in cycle 1, result=0; next legal start clears error.
REQ-031 Pulse start during busy with different operands -> ignored, first result unchanged; reset_n low at cycle 200 -> outputs 0, no done; restart completes correctly.
